// File: rtl/sipo_sched_pkg.sv
// -----------------------------------------------------------------------------
// Package: sipo_sched_pkg
// Purpose: Shared types and helpers for the SIPO round-robin scheduler slice.
// Contents:
//   sched_state_t  scheduler FSM state encoding
//   SIPO_W         width of the shared deserializer (bits per frame)
//   clog2_min1     index width helper that never returns 0
// -----------------------------------------------------------------------------
package sipo_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT    = 2'd1,
        WAIT_OUT = 2'd2,
        GAP      = 2'd3
    } sched_state_t;

    localparam int SIPO_W = 4;

    // $clog2 returns 0 for n<=1, which would give zero-width vectors.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sipo_rr_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Module: rr_arbiter
// Purpose: Purely combinational round-robin pick. The winner is the first set
//          request index strictly after ptr, wrapping around N.
// Ports:
//   req         in   N     request vector
//   ptr         in   IW    index of the previous winner (lowest priority now)
//   gnt_onehot  out  N     one-hot winner, zero when nothing requests
//   gnt_idx     out  IW    binary index of the winner
//   any         out  1     at least one request is set
// -----------------------------------------------------------------------------
module rr_arbiter
    import sipo_sched_pkg::*;
#(
    parameter int N  = 4,
    localparam int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int idx;

    // Scan from ptr+1 upward; the first hit wins, later hits are ignored.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = 0;
        for (int off = 1; off <= N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = IW'(idx);
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// Module: sipo_rr_scheduler
// Purpose: Shares one serial-in/parallel-out deserializer among NUM_REQ serial
//          sources. Grants one source per frame in round-robin order, muxes its
//          bit stream into the deserializer, and returns the parallel word
//          tagged with the source index.
// Ports:
//   clk             in   1            clock, rising edge
//   rst_n           in   1            asynchronous active-low reset
//   req             in   NUM_REQ      per-source frame request (level)
//   s_in            in   NUM_REQ      per-source serial bit
//   grant           out  NUM_REQ      one-hot grant, high while the frame shifts
//   sipo_in_valid   out  1            deserializer in_valid
//   sipo_s_in       out  1            deserializer serial input
//   sipo_out_valid  in   1            deserializer out_valid
//   sipo_p_out      in   FRAME_BITS   deserializer parallel word
//   out_valid       out  1            one-cycle pulse, out_data/out_id valid
//   out_data        out  FRAME_BITS   captured word
//   out_id          out  IDW          source index of out_data
//   abort           out  1            one-cycle pulse on request drop or timeout
//   busy            out  1            FSM is not in IDLE
// -----------------------------------------------------------------------------
module sipo_rr_scheduler
    import sipo_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FRAME_BITS = SIPO_W,
    parameter int GAP_CYCLES = 1,
    parameter int TIMEOUT    = 8,
    localparam int IDW       = clog2_min1(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    s_in,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  sipo_in_valid,
    output logic                  sipo_s_in,
    input  logic                  sipo_out_valid,
    input  logic [FRAME_BITS-1:0] sipo_p_out,
    output logic                  out_valid,
    output logic [FRAME_BITS-1:0] out_data,
    output logic [IDW-1:0]        out_id,
    output logic                  abort,
    output logic                  busy
);

    localparam int BCW = clog2_min1(FRAME_BITS);
    localparam int TCW = $clog2(TIMEOUT + 1);
    localparam int GCW = clog2_min1(GAP_CYCLES + 1);

    localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME_BITS - 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT - 1);
    localparam logic [TCW-1:0] TMO_MAX  = TCW'(TIMEOUT);
    localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_CYCLES - 1);
    localparam logic [GCW-1:0] GAP_MAX  = GCW'(GAP_CYCLES);

    sched_state_t state, state_next;

    logic [IDW-1:0]     gid;
    logic [IDW-1:0]     ptr;
    logic [BCW-1:0]     bit_cnt;
    logic [TCW-1:0]     tmo_cnt;
    logic [GCW-1:0]     gap_cnt;

    logic [NUM_REQ-1:0] arb_onehot;
    logic [IDW-1:0]     arb_idx;
    logic               arb_any;
    logic [NUM_REQ-1:0] gid_onehot;
    logic               gid_req;

    // Arbitration only matters in IDLE; its result is registered into gid.
    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .req        (req),
        .ptr        (ptr),
        .gnt_onehot (arb_onehot),
        .gnt_idx    (arb_idx),
        .any        (arb_any)
    );

    assign gid_onehot = NUM_REQ'(1) << gid;
    assign gid_req    = req[gid];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A request drop during SHIFT takes priority over the last-bit check, and
    // deserializer data takes priority over the timeout in WAIT_OUT.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (!gid_req) begin
                    state_next = GAP;
                end else if (bit_cnt == BIT_LAST) begin
                    state_next = WAIT_OUT;
                end
            end
            WAIT_OUT: begin
                if (sipo_out_valid || (tmo_cnt == TMO_LAST)) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters are cleared in IDLE (every frame passes through it) and only
    // advanced in their own state; they saturate rather than wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gid       <= '0;
            ptr       <= IDW'(NUM_REQ - 1);
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            grant     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            abort     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            abort     <= 1'b0;

            // Grant is high for exactly the cycles spent in SHIFT.
            if (state_next == SHIFT) begin
                grant <= (state == IDLE) ? arb_onehot : gid_onehot;
            end else begin
                grant <= '0;
            end

            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    tmo_cnt <= '0;
                    gap_cnt <= '0;
                    if (arb_any) begin
                        gid <= arb_idx;
                        ptr <= arb_idx;
                    end
                end
                SHIFT: begin
                    if (!gid_req) begin
                        abort <= 1'b1;
                    end
                    if (bit_cnt != BIT_LAST) begin
                        bit_cnt <= bit_cnt + BCW'(1);
                    end
                end
                WAIT_OUT: begin
                    if (sipo_out_valid) begin
                        out_data  <= sipo_p_out;
                        out_id    <= gid;
                        out_valid <= 1'b1;
                    end else if (tmo_cnt == TMO_LAST) begin
                        abort <= 1'b1;
                    end
                    if (tmo_cnt != TMO_MAX) begin
                        tmo_cnt <= tmo_cnt + TCW'(1);
                    end
                end
                GAP: begin
                    if (gap_cnt != GAP_MAX) begin
                        gap_cnt <= gap_cnt + GCW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // The serial mux is combinational so a request drop blanks in_valid in
    // the very cycle it happens.
    always_comb begin
        sipo_in_valid = 1'b0;
        sipo_s_in     = 1'b0;
        busy          = (state != IDLE);
        if ((state == SHIFT) && gid_req) begin
            sipo_in_valid = 1'b1;
            sipo_s_in     = s_in[gid];
        end
    end

endmodule

// File: tb/tb_sipo_rr_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench: tb_sipo_rr_scheduler
// Purpose: Directed self-checking bench for sipo_rr_scheduler with a simple
//          4-bit deserializer model (out_valid one cycle after the 4th bit).
// -----------------------------------------------------------------------------
module tb_sipo_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] s_in;
    logic [3:0] grant;
    logic       sipo_in_valid;
    logic       sipo_s_in;
    logic       sipo_out_valid;
    logic [3:0] sipo_p_out;
    logic       out_valid;
    logic [3:0] out_data;
    logic [1:0] out_id;
    logic       abort;
    logic       busy;

    int tests_run;
    int fail_cnt;

    // Deserializer model and stray-pulse injection
    logic [3:0] mdl_sr;
    logic [3:0] mdl_word;
    logic [1:0] mdl_cnt;
    logic       mdl_valid;
    logic       des_en;
    logic       stray_valid;
    logic [3:0] stray_data;

    sipo_rr_scheduler #(
        .NUM_REQ    (4),
        .FRAME_BITS (4),
        .GAP_CYCLES (1),
        .TIMEOUT    (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .s_in           (s_in),
        .grant          (grant),
        .sipo_in_valid  (sipo_in_valid),
        .sipo_s_in      (sipo_s_in),
        .sipo_out_valid (sipo_out_valid),
        .sipo_p_out     (sipo_p_out),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_id         (out_id),
        .abort          (abort),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Deserializer: shifts MSB-first, flushes when in_valid drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl_sr    <= '0;
            mdl_word  <= '0;
            mdl_cnt   <= '0;
            mdl_valid <= 1'b0;
        end else begin
            mdl_valid <= 1'b0;
            if (sipo_in_valid) begin
                mdl_sr <= {mdl_sr[2:0], sipo_s_in};
                if (mdl_cnt == 2'd3) begin
                    mdl_cnt   <= '0;
                    mdl_word  <= {mdl_sr[2:0], sipo_s_in};
                    mdl_valid <= des_en;
                end else begin
                    mdl_cnt <= mdl_cnt + 2'd1;
                end
            end else begin
                mdl_cnt <= '0;
            end
        end
    end

    assign sipo_out_valid = mdl_valid | stray_valid;
    assign sipo_p_out     = stray_valid ? stray_data : mdl_word;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            fail_cnt++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for any grant, checking in_valid stays low meanwhile.
    task automatic waitGrant(output int waited);
        waited = 0;
        while ((grant == 4'd0) && (waited < 20)) begin
            checkOutput("idle_in_valid", 32'(sipo_in_valid), 0);
            tick();
            waited++;
        end
    endtask

    // Runs one frame from src. drop_at<4 drops req[src] before that bit.
    task automatic applyStimulus(input int src, input logic [3:0] word,
                                 input int drop_at, input bit expect_data,
                                 output int waited);
        bit dropped;
        dropped = 1'b0;
        waitGrant(waited);
        checkOutput("grant_winner", 32'(grant), 32'(1 << src));
        checkOutput("busy_shift", 32'(busy), 1);
        for (int i = 0; i < 4; i++) begin
            if (i == drop_at) begin
                req[src] = 1'b0;
            end
            s_in[src] = word[3-i];
            #1;
            if (i == drop_at) begin
                checkOutput("drop_in_valid", 32'(sipo_in_valid), 0);
                tick();
                checkOutput("drop_abort", 32'(abort), 1);
                checkOutput("drop_out_valid", 32'(out_valid), 0);
                dropped = 1'b1;
                break;
            end
            checkOutput("grant_hold", 32'(grant), 32'(1 << src));
            checkOutput("shift_in_valid", 32'(sipo_in_valid), 1);
            checkOutput("shift_s_in", 32'(sipo_s_in), 32'(word[3-i]));
            tick();
        end
        s_in = 4'd0;
        if (!dropped) begin
            checkOutput("wait_grant_low", 32'(grant), 0);
            checkOutput("wait_in_valid", 32'(sipo_in_valid), 0);
            if (expect_data) begin
                tick();
                checkOutput("out_valid", 32'(out_valid), 1);
                checkOutput("out_data", 32'(out_data), 32'(word));
                checkOutput("out_id", 32'(out_id), 32'(src));
                checkOutput("no_abort", 32'(abort), 0);
            end
        end
    endtask

    logic [3:0] words [8];
    int         waited;

    initial begin
        tests_run   = 0;
        fail_cnt    = 0;
        rst_n       = 1'b0;
        req         = 4'd0;
        s_in        = 4'd0;
        des_en      = 1'b1;
        stray_valid = 1'b0;
        stray_data  = 4'd0;
        words       = '{4'hA, 4'h5, 4'h3, 4'hC, 4'h9, 4'h6, 4'hF, 4'h1};

        // Reset values
        #2;
        checkOutput("rst_grant", 32'(grant), 0);
        checkOutput("rst_in_valid", 32'(sipo_in_valid), 0);
        checkOutput("rst_s_in", 32'(sipo_s_in), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_out_data", 32'(out_data), 0);
        checkOutput("rst_out_id", 32'(out_id), 0);
        checkOutput("rst_abort", 32'(abort), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // All sources requesting: strict rotation 0,1,2,3,0,1,2,3
        $display("[TB] all-request rotation");
        req = 4'b1111;
        for (int f = 0; f < 8; f++) begin
            applyStimulus(f % 4, words[f], 4, 1'b1, waited);
            if (f > 0) begin
                checkOutput("gap_then_idle", 32'(waited), 2);
            end
        end
        req = 4'd0;
        tick();
        tick();

        // Single requester 2 sends 1011
        $display("[TB] single request");
        req = 4'b0100;
        applyStimulus(2, 4'b1011, 4, 1'b1, waited);
        req = 4'd0;
        tick();
        checkOutput("pulse_end", 32'(out_valid), 0);
        checkOutput("back_idle", 32'(busy), 0);

        // Request drop after two bits, then next requester wins
        $display("[TB] request drop");
        req = 4'b0110;
        applyStimulus(1, 4'b1100, 2, 1'b0, waited);
        tick();
        checkOutput("abort_one_cycle", 32'(abort), 0);
        checkOutput("drop_no_data", 32'(out_valid), 0);
        applyStimulus(2, 4'b0110, 4, 1'b1, waited);
        req = 4'd0;
        tick();
        tick();

        // Deserializer never answers: abort exactly TIMEOUT cycles later
        $display("[TB] timeout");
        des_en = 1'b0;
        req    = 4'b0001;
        applyStimulus(0, 4'b1001, 4, 1'b0, waited);
        req = 4'd0;
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        checkOutput("tmo_early", 32'(abort), 0);
        checkOutput("tmo_busy", 32'(busy), 1);
        tick();
        checkOutput("tmo_abort", 32'(abort), 1);
        checkOutput("tmo_no_data", 32'(out_valid), 0);
        tick();
        checkOutput("tmo_abort_end", 32'(abort), 0);
        checkOutput("tmo_idle", 32'(busy), 0);
        des_en = 1'b1;

        // Stray out_valid while idle is ignored
        $display("[TB] stray out_valid");
        stray_data  = 4'hF;
        stray_valid = 1'b1;
        tick();
        stray_valid = 1'b0;
        checkOutput("stray_out_valid", 32'(out_valid), 0);
        checkOutput("stray_out_data", 32'(out_data), 32'h6);
        checkOutput("stray_out_id", 32'(out_id), 2);
        tick();
        checkOutput("stray_late", 32'(out_valid), 0);

        // Reset mid-SHIFT clears everything and restores the pointer
        $display("[TB] reset mid-frame");
        req = 4'b0100;
        waitGrant(waited);
        checkOutput("pre_rst_grant", 32'(grant), 32'h4);
        s_in[2] = 1'b1;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_grant", 32'(grant), 0);
        checkOutput("arst_in_valid", 32'(sipo_in_valid), 0);
        checkOutput("arst_s_in", 32'(sipo_s_in), 0);
        checkOutput("arst_out_valid", 32'(out_valid), 0);
        checkOutput("arst_out_data", 32'(out_data), 0);
        checkOutput("arst_out_id", 32'(out_id), 0);
        checkOutput("arst_abort", 32'(abort), 0);
        checkOutput("arst_busy", 32'(busy), 0);
        s_in = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        waitGrant(waited);
        checkOutput("post_rst_winner", 32'(grant), 32'h1);
        checkOutput("post_rst_abort", 32'(abort), 0);
        req = 4'd0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
